secure_reg_arbiter: RTL and testbench
=====================================

Name: secure_reg_arbiter

Overview:
Shares one DATA_W-bit holding register between NUM_REQ requesters using round-robin arbitration. Guarantees the register contents are zeroed when ownership is released. No owner can observe a previous owner's data. Sits between requester-side datapaths and the shared secure storage. Also flags write attempts by non-owners.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, holding-register width
SCRUB_CYCLES, 2, cycles spent in SCRUB after release (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester ownership request, level; held for the whole tenure
wr_en  input  NUM_REQ  per-requester write strobe
wr_data  input  NUM_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  registered one-hot grant, all-zero when no owner
rd_data  output  DATA_W  holding-register value while in GRANT, else 0 (combinational mask)
busy  output  1  high in GRANT or SCRUB
scrub_done  output  1  one-cycle pulse on the first IDLE cycle after a scrub
viol  output  1  registered one-cycle pulse: a non-owner asserted wr_en the previous cycle

Behaviour:
- Reset (async, any time, including mid-GRANT or mid-SCRUB):
  - state=IDLE, data_reg=0, gnt=0, busy=0, scrub_done=0, viol=0, scrub counter=0.
  - rr pointer=NUM_REQ-1, so requester 0 has first priority.
- States are IDLE, GRANT and SCRUB.
- IDLE:
  - data_reg is already 0.
  - If any req bit is set at an edge, select the first set bit searching from pointer+1 upward with wrap-around.
  - After that edge: state=GRANT, gnt=onehot(sel), pointer=sel.
  - Grant latency is 1 cycle from req being sampled.
  - If no req bit is set, remain in IDLE.
- GRANT (owner o):
  - If req[o]=1 and wr_en[o]=1 at an edge, data_reg<=wr_data[o] after that edge.
  - rd_data=data_reg during GRANT.
  - If req[o]=0 at an edge (release), all of the following take effect after that edge:
    - gnt=0 and data_reg=0
    - state=SCRUB and counter=SCRUB_CYCLES-1
    - any wr_en[o] in that same cycle is discarded; scrub wins.
  - Other requesters' req bits are ignored during GRANT; there is no preemption.
- SCRUB:
  - data_reg is held at 0; all writes are ignored; gnt=0.
  - The counter decrements each edge.
  - At the edge where the counter=0: state=IDLE and scrub_done=1 for exactly one cycle.
  - Total handover time, release sample to next gnt: SCRUB_CYCLES+2 edges, i.e. 1 edge to enter SCRUB, SCRUB_CYCLES edges in SCRUB, then 1 IDLE edge to arbitrate.
- viol:
  - At an edge, any wr_en[i]=1 with i≠current owner (or any wr_en in IDLE/SCRUB) sets viol=1 for the next cycle.
  - Otherwise viol=0.
  - The offending write never reaches data_reg.
  - A release-cycle write by the owner is not a violation.
- busy = (state != IDLE).
- gnt is always one-hot or zero; no two grants are ever active at once.

Test Plan:
- After reset, req=4'b0110 -> gnt=4'b0010 one cycle later. Holding req, wr_en[1], wr_data[1]=32'hDEADBEEF -> rd_data=32'hDEADBEEF next cycle.
- Owner 1 drops req while req[2]=1, SCRUB_CYCLES=2:
  - data_reg=0 the very next cycle.
  - gnt=0 for 3 cycles; scrub_done pulses once.
  - gnt=4'b0100 afterwards; rd_data reads 0 before requester 2 writes.
- Round-robin fairness with req=4'b1111 held, each owner releasing after 1 write -> grant order 0,1,2,3,0, with a scrub between every handover.
- Requester 3 asserts wr_en with 32'h12345678 while requester 0 owns -> viol=1 for one cycle; data_reg unchanged.
- Owner drops req and asserts wr_en with 32'hCAFEF00D in the same cycle -> write discarded, data_reg=0, viol=0.
- rst asserted asynchronously mid-GRANT, with data_reg=32'hA5A5A5A5 -> without waiting for a clock edge: data_reg=0, gnt=0, busy=0, rd_data=0. After release, req[3] alone -> gnt=4'b1000 after 1 cycle.

Source files
------------

// File: rtl/secure_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : secure_reg_arbiter_if
// Description : Requester-side bus of the secure holding-register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface secure_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        wr_en;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         rd_data;
    logic                      busy;
    logic                      scrub_done;
    logic                      viol;

    modport master (
        output req, wr_en, wr_data,
        input  gnt, rd_data, busy, scrub_done, viol
    );

    modport slave (
        input  req, wr_en, wr_data,
        output gnt, rd_data, busy, scrub_done, viol
    );
endinterface
`default_nettype wire

// File: rtl/secure_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : secure_reg_arbiter
// Description : Round-robin owner of one holding register, scrubbed on release.
// Revision    : 1.0 - initial release
// ============================================================================
module secure_reg_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int SCRUB_CYCLES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    secure_reg_arbiter_if.slave  bus
);
    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SCRUB = 2'd2
    } state_t;

    state_t               r_state;
    logic [DATA_W-1:0]    r_data;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_scrub_done;
    logic                 r_viol;

    logic                 w_any;
    logic [c_PTR_W-1:0]   w_sel;
    logic [c_PTR_W-1:0]   w_cand;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [DATA_W-1:0]    w_owner_data;
    logic                 w_viol;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = r_ptr;
        w_cand = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any) begin
                if (int'(r_ptr) + k >= NUM_REQ)
                    w_cand = c_PTR_W'(int'(r_ptr) + k - NUM_REQ);
                else
                    w_cand = c_PTR_W'(int'(r_ptr) + k);
                if (bus.req[w_cand]) begin
                    w_any = 1'b1;
                    w_sel = w_cand;
                end
            end
        end
    end

    assign w_onehot     = NUM_REQ'(1) << w_sel;
    assign w_owner_data = bus.wr_data[int'(r_ptr)*DATA_W +: DATA_W];
    // r_gnt is zero outside GRANT, so any strobe there counts as a violation.
    assign w_viol       = |(bus.wr_en & ~r_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_data       <= '0;
            r_gnt        <= '0;
            r_ptr        <= c_PTR_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_scrub_done <= 1'b0;
            r_viol       <= 1'b0;
        end else begin
            r_viol       <= w_viol;
            r_scrub_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_GRANT;
                        r_gnt   <= w_onehot;
                        r_ptr   <= w_sel;
                    end
                end
                S_GRANT: begin
                    if (!bus.req[r_ptr]) begin
                        r_state <= S_SCRUB;
                        r_gnt   <= '0;
                        r_data  <= '0;
                        r_cnt   <= c_CNT_W'(SCRUB_CYCLES - 1);
                    end else if (bus.wr_en[r_ptr]) begin
                        r_data <= w_owner_data;
                    end
                end
                S_SCRUB: begin
                    r_data <= '0;
                    r_gnt  <= '0;
                    if (r_cnt == '0) begin
                        r_state      <= S_IDLE;
                        r_scrub_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_data  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.rd_data    = (r_state == S_GRANT) ? r_data : '0;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.scrub_done = r_scrub_done;
    assign bus.viol       = r_viol;
endmodule
`default_nettype wire

// File: tb/tb_secure_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_secure_reg_arbiter
// Description : Directed bench with a phase-level model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secure_reg_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    secure_reg_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    secure_reg_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .SCRUB_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 = free, 1 = owned, 2 = scrubbing with m_left edges to go.
    int              m_phase, m_ptr, m_left, m_cand;
    bit              m_found, m_viol, m_done;
    logic [DW-1:0]   m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_ptr = NR - 1; m_left = 0;
            m_data = '0; m_viol = 0; m_done = 0;
        end else begin
            m_viol = 0;
            for (int i = 0; i < NR; i++)
                if (bus.wr_en[i] && !(m_phase == 1 && i == m_ptr)) m_viol = 1;
            m_done = 0;
            case (m_phase)
                0: begin
                    m_found = 0;
                    for (int k = 1; k <= NR; k++) begin
                        m_cand = (m_ptr + k) % NR;
                        if (!m_found && bus.req[m_cand]) begin
                            m_found = 1;
                            m_ptr   = m_cand;
                        end
                    end
                    if (m_found) m_phase = 1;
                end
                1: begin
                    if (!bus.req[m_ptr]) begin
                        m_phase = 2; m_data = '0; m_left = SC;
                    end else if (bus.wr_en[m_ptr]) begin
                        m_data = bus.wr_data[m_ptr*DW +: DW];
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 0; m_done = 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_gnt",   bus.gnt,        (m_phase == 1) ? (64'd1 << m_ptr) : 64'd0);
        chk("cyc_rd",    bus.rd_data,    (m_phase == 1) ? m_data : '0);
        chk("cyc_busy",  bus.busy,       m_phase != 0);
        chk("cyc_done",  bus.scrub_done, m_done);
        chk("cyc_viol",  bus.viol,       m_viol);
        chk("cyc_1hot",  $countones(bus.gnt) <= 1, 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input logic [DW-1:0] v);
        bus.wr_en = '0;
        bus.wr_en[i] = 1'b1;
        bus.wr_data[i*DW +: DW] = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        chk("wait_idle", bus.busy, 0);
    endtask

    int gap;
    int rr_exp[5];

    initial begin
        bus.req = '0; bus.wr_en = '0; bus.wr_data = '0;
        rr_exp = '{0, 1, 2, 3, 0};
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rd", bus.rd_data, 0);
        chk("rst_viol", bus.viol, 0);

        // First grant goes to lowest requester after reset.
        tick();
        bus.req = 4'b0110;
        tick();
        chk("g1_gnt", bus.gnt, 4'b0010);
        set_wr(1, 32'hDEADBEEF);
        tick();
        bus.wr_en = '0;
        chk("g1_rd", bus.rd_data, 32'hDEADBEEF);

        // Owner 1 releases while 2 waits.
        bus.req = 4'b0100;
        tick();
        chk("rel_rd", bus.rd_data, 0);
        chk("rel_gnt0", bus.gnt, 0);
        chk("rel_busy", bus.busy, 1);
        tick();
        chk("rel_gnt1", bus.gnt, 0);
        chk("rel_done_lo", bus.scrub_done, 0);
        tick();
        chk("rel_gnt2", bus.gnt, 0);
        chk("rel_done_hi", bus.scrub_done, 1);
        tick();
        chk("rel_gnt_next", bus.gnt, 4'b0100);
        chk("rel_done_off", bus.scrub_done, 0);
        chk("rel_rd_clean", bus.rd_data, 0);
        bus.req = '0;
        tick();
        wait_idle();

        // Non-owner write is flagged and dropped.
        bus.req = 4'b0001;
        tick();
        chk("v_gnt", bus.gnt, 4'b0001);
        set_wr(0, 32'h11111111);
        tick();
        chk("v_rd0", bus.rd_data, 32'h11111111);
        set_wr(3, 32'h12345678);
        tick();
        bus.wr_en = '0;
        chk("v_viol", bus.viol, 1);
        chk("v_rd_kept", bus.rd_data, 32'h11111111);
        tick();
        chk("v_viol_off", bus.viol, 0);

        // Release-cycle write by the owner is discarded without a violation.
        bus.req = '0;
        set_wr(0, 32'hCAFEF00D);
        tick();
        bus.wr_en = '0;
        chk("rw_rd", bus.rd_data, 0);
        chk("rw_gnt", bus.gnt, 0);
        tick();
        chk("rw_viol", bus.viol, 0);
        wait_idle();

        // Asynchronous reset in the middle of a tenure.
        bus.req = 4'b0100;
        tick();
        chk("ar_gnt", bus.gnt, 4'b0100);
        set_wr(2, 32'hA5A5A5A5);
        tick();
        bus.wr_en = '0;
        chk("ar_rd", bus.rd_data, 32'hA5A5A5A5);
        #2 rst = 1'b1;
        #1;
        chk("ar_gnt0", bus.gnt, 0);
        chk("ar_busy0", bus.busy, 0);
        chk("ar_rd0", bus.rd_data, 0);
        tick();
        bus.req = 4'b1000;
        #3 rst = 1'b0;
        tick();
        chk("ar_gnt3", bus.gnt, 4'b1000);
        bus.req = '0;
        tick();
        wait_idle();

        // Round-robin with everyone requesting; pointer sits at 3.
        bus.req = 4'b1111;
        tick();
        for (int r = 0; r < 5; r++) begin
            chk("rr_gnt", bus.gnt, 64'd1 << rr_exp[r]);
            chk("rr_rd0", bus.rd_data, 0);
            set_wr(rr_exp[r], 32'h100 + r);
            tick();
            bus.wr_en = '0;
            chk("rr_rd", bus.rd_data, 32'h100 + r);
            bus.req[rr_exp[r]] = 1'b0;
            tick();
            bus.req[rr_exp[r]] = 1'b1;
            gap = 0;
            while (bus.gnt == '0 && gap < 20) begin
                gap++;
                tick();
            end
            chk("rr_gap", gap, SC + 1);
        end
        bus.req = '0;
        tick();
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
